// File: rtl/score_disp_pkg.sv
// Shared widths, BCD vector type and conversion FSM state for the score display.
// Consumers: score_bin2bcd (converter) and score_scan_ctrl (scan/mux top).
package score_disp_pkg;

    localparam int unsigned NUM_DIGITS   = 8;
    localparam int unsigned SCORE_DIGITS = 5;
    localparam int unsigned SCORE_W      = 16;
    localparam int unsigned BCD_W        = 4;
    localparam int unsigned REFCNT_W     = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W        = $clog2(SCORE_W);

    typedef logic [SCORE_DIGITS-1:0][BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } conv_state_t;

    // Shift-add-3 correction applied to every digit before each shift.
    function automatic bcd_t dabble_adjust(input bcd_t v);
        bcd_t r;
        r = v;
        for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
            if (v[i] > BCD_W'(4)) begin
                r[i] = v[i] + BCD_W'(3);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/score_bin2bcd.sv
// Sequential 16-bit binary to 5-digit BCD converter, one bit per cycle.
// Handshake: load sampled in IDLE, busy through SHIFT/COMMIT, done_c pulses in COMMIT.
module score_bin2bcd
    import score_disp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [SCORE_W-1:0] bin,
    output logic               busy,
    output logic               done_c,
    output bcd_t               bcd
);

    conv_state_t        state;
    conv_state_t        state_nxt;
    logic [SCORE_W-1:0] sreg;
    logic [SCORE_W-1:0] sreg_nxt;
    bcd_t               acc;
    bcd_t               acc_nxt;
    bcd_t               adj;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    // State register; busy is registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            sreg <= sreg_nxt;
            acc  <= acc_nxt;
            cnt  <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        done_c    = 1'b0;
        adj       = dabble_adjust(acc);
        case (state)
            ST_IDLE: begin
                if (load) begin
                    sreg_nxt  = bin;
                    acc_nxt   = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {acc_nxt, sreg_nxt} = {adj, sreg} << 1;
                cnt_nxt             = cnt + CNT_W'(1);
                if (cnt == CNT_W'(SCORE_W - 1)) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                done_c    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bcd = acc;

endmodule

// File: rtl/score_scan_ctrl.sv
// Score display controller: binary-to-BCD load path plus an 8-slot multiplexed digit scan.
// Optional SEG_LZB_EN: blank leading zero digits 1..4 (digit 0 always shown).
module score_scan_ctrl
    import score_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SCORE_W-1:0]  score_in,
    input  logic                score_load,
    output logic                busy,
    output logic [REFCNT_W-1:0] refcnt,
    output logic [BCD_W-1:0]    digit,
    output logic                digit_blank
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [PRE_W-1:0] prescale;
    bcd_t             display;
    bcd_t             conv_bcd;
    logic             conv_done_c;

    score_bin2bcd u_bin2bcd (
        .clk    (clk),
        .rst    (rst),
        .load   (score_load),
        .bin    (score_in),
        .busy   (busy),
        .done_c (conv_done_c),
        .bcd    (conv_bcd)
    );

    // Free-running slot timer; never touched by the conversion path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            refcnt   <= '0;
        end else if (prescale == PRE_W'(REFRESH_DIV - 1)) begin
            prescale <= '0;
            refcnt   <= refcnt + REFCNT_W'(1);
        end else begin
            prescale <= prescale + PRE_W'(1);
        end
    end

    // Display only changes on the COMMIT exit, so a conversion never tears the shown value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            display <= '0;
        end else if (conv_done_c) begin
            display <= conv_bcd;
        end
    end

`ifdef SEG_LZB_EN
    logic [SCORE_DIGITS-1:0] lz_mask;
    logic                    above_zero;

    always_comb begin
        lz_mask    = '0;
        above_zero = 1'b1;
        for (int i = int'(SCORE_DIGITS) - 1; i > 0; i--) begin
            above_zero = above_zero && (display[i] == '0);
            lz_mask[i] = above_zero;
        end
    end
`endif

    always_comb begin
        digit       = '0;
        digit_blank = 1'b1;
        if (refcnt < REFCNT_W'(SCORE_DIGITS)) begin
            digit       = display[refcnt];
`ifdef SEG_LZB_EN
            digit_blank = lz_mask[refcnt];
`else
            digit_blank = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_score_scan_ctrl.sv
// Directed bench for score_scan_ctrl with REFRESH_DIV=4: scan order, conversion vectors,
// load-ignore, no-tearing and mid-conversion reset sequences.
module tb_score_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] score_in;
    logic        score_load;
    logic        busy;
    logic [2:0]  refcnt;
    logic [3:0]  digit;
    logic        digit_blank;

    int unsigned nvec;
    int unsigned nfail;

    typedef struct {
        logic [15:0] score;
        logic [19:0] bcd;
    } vec_t;

    vec_t vecs[10];

    score_scan_ctrl #(.REFRESH_DIV(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .score_in    (score_in),
        .score_load  (score_load),
        .busy        (busy),
        .refcnt      (refcnt),
        .digit       (digit),
        .digit_blank (digit_blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        nvec++;
        if (actual != expected) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic exp_blank(input logic [19:0] bcd, input int k);
        logic b;
        if (k >= 5) return 1'b1;
        b = 1'b0;
`ifdef SEG_LZB_EN
        if (k >= 1) begin
            b = 1'b1;
            for (int j = k; j < 5; j++) begin
                if (bcd[j*4 +: 4] != 4'd0) b = 1'b0;
            end
        end
`endif
        return b;
    endfunction

    // Waits (bounded) for slot k, called and returning on a falling edge.
    task automatic read_slot(input int k, output logic [3:0] d, output logic b, output bit ok);
        for (int t = 0; t < 64 && refcnt != 3'(k); t++) @(negedge clk);
        ok = (refcnt == 3'(k));
        d  = digit;
        b  = digit_blank;
    endtask

    task automatic check_display(input string name, input logic [19:0] bcd);
        logic [3:0] d;
        logic       b;
        bit         ok;
        for (int k = 0; k < 8; k++) begin
            read_slot(k, d, b, ok);
            if (!ok) begin
                nvec++;
                nfail++;
                $display("FAIL %s slot %0d: refcnt never reached slot", name, k);
            end else begin
                check($sformatf("%s digit[%0d]", name, k), int'(d), (k < 5) ? int'(bcd[k*4 +: 4]) : 0);
                check($sformatf("%s blank[%0d]", name, k), int'(b), int'(exp_blank(bcd, k)));
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v, output int busy_cycles);
        score_in   = v;
        score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        busy_cycles = 0;
        while (busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int          bc;
        logic [19:0] shown;
        nvec       = 0;
        nfail      = 0;
        rst        = 1'b1;
        score_load = 1'b0;
        score_in   = '0;

        vecs[0] = '{16'd65535, 20'h65535};
        vecs[1] = '{16'd0,     20'h00000};
        vecs[2] = '{16'd70,    20'h00070};
        vecs[3] = '{16'd9,     20'h00009};
        vecs[4] = '{16'd100,   20'h00100};
        vecs[5] = '{16'd10009, 20'h10009};
        vecs[6] = '{16'd40000, 20'h40000};
        vecs[7] = '{16'd4321,  20'h04321};
        vecs[8] = '{16'd59999, 20'h59999};
        vecs[9] = '{16'd7,     20'h00007};

        repeat (3) @(negedge clk);
        check("reset refcnt", int'(refcnt), 0);
        check("reset busy", int'(busy), 0);
        check("reset digit", int'(digit), 0);
        check("reset blank", int'(digit_blank), 0);

        // Scan order straight out of reset: slot advances every 4 cycles.
        rst = 1'b0;
        for (int k = 0; k < 36; k++) begin
            check($sformatf("scan refcnt@%0d", k), int'(refcnt), (k / 4) % 8);
            check($sformatf("scan digit@%0d", k), int'(digit), 0);
            check($sformatf("scan blank@%0d", k), int'(digit_blank), int'(exp_blank(20'h0, (k / 4) % 8)));
            @(negedge clk);
        end

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].score, bc);
            check($sformatf("busy len v%0d", i), bc, 17);
            check_display($sformatf("vec%0d", i), vecs[i].bcd);
        end

        // Loads during SHIFT and in the COMMIT cycle are dropped.
        score_in   = 16'd1234;
        score_load = 1'b1;
        for (int n = 1; n <= 19; n++) begin
            @(negedge clk);
            score_load = 1'b0;
            if (n == 5 || n == 17) begin
                score_in   = 16'd999;
                score_load = 1'b1;
            end
            if (n == 17) check("commit busy", int'(busy), 1);
            if (n == 19) check("ignored load busy", int'(busy), 0);
        end
        check_display("ignore", 20'h01234);

        // Old value (7) shown throughout the conversion of 42.
        do_load(16'd7, bc);
        score_in   = 16'd42;
        score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            shown = 20'h00007;
            check($sformatf("hold digit@%0d", bc), int'(digit),
                  (refcnt < 3'd5) ? int'(shown[refcnt*4 +: 4]) : 0);
            bc++;
            @(negedge clk);
        end
        check("tear busy len", bc, 17);
        check_display("after42", 20'h00042);

        // Reset in SHIFT cycle 8 aborts without committing.
        score_in   = 16'd500;
        score_load = 1'b1;
        @(negedge clk);
        score_load = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort busy", int'(busy), 0);
        check("abort refcnt", int'(refcnt), 0);
        check("abort digit", int'(digit), 0);
        @(negedge clk);
        rst = 1'b0;
        check_display("abort", 20'h00000);
        do_load(16'd9, bc);
        check("post-reset busy len", bc, 17);
        check_display("post-reset", 20'h00009);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
